// File: rtl/sq_pkg.sv
// Shared types for the store queue: drain FSM states, entry layout, default depth.
package sq_pkg;

    localparam int unsigned SqDepthDefault = 4;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StWrite = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] tag;
        logic        committed;
    } sq_entry_t;

endpackage

// File: rtl/sq_fifo_mem.sv
// Store-queue entry storage with circular head/tail pointers and occupancy count.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   enq0, enq0_entry        write entry at tail
//   enq1, enq1_entry        write entry at tail (+1 when enq0 also set)
//   commit_set              one-hot (or zero) mask of entries to mark committed
//   deq                     retire the head entry
//   flush                   cut tail back to the first uncommitted entry from head
//   entries, head           storage and head pointer, visible to the controller
//   count, empty, full      registered occupancy status
module sq_fifo_mem
    import sq_pkg::*;
#(
    parameter int unsigned DEPTH = SqDepthDefault
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enq0,
    input  sq_entry_t                enq0_entry,
    input  logic                     enq1,
    input  sq_entry_t                enq1_entry,
    input  logic [DEPTH-1:0]         commit_set,
    input  logic                     deq,
    input  logic                     flush,
    output sq_entry_t                entries [DEPTH],
    output logic [$clog2(DEPTH)-1:0] head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    sq_entry_t       mem_q [DEPTH];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            empty_q, full_q;

    logic [DEPTH-1:0] committed_next;
    logic [CntW-1:0]  keep;
    logic             stop;
    logic [PtrW-1:0]  idx;
    logic [PtrW-1:0]  wr1_idx;

    always_comb begin
        committed_next = '0;
        keep           = '0;
        stop           = 1'b0;
        idx            = '0;

        // Commit is applied before the flush looks for the first uncommitted entry.
        for (int i = 0; i < DEPTH; i++) begin
            committed_next[i] = mem_q[i].committed | commit_set[i];
        end

        // Length of the committed run starting at head; that is what survives a flush.
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PtrW'(k);
            if (!stop && (CntW'(k) < count_q) && committed_next[idx]) begin
                keep = keep + CntW'(1);
            end else begin
                stop = 1'b1;
            end
        end

        head_d  = deq ? head_q + PtrW'(1) : head_q;
        wr1_idx = tail_q + PtrW'(enq0);

        if (flush) begin
            tail_d  = head_q + keep[PtrW-1:0];
            count_d = keep - CntW'(deq);
        end else begin
            tail_d  = tail_q + PtrW'(enq0) + PtrW'(enq1);
            count_d = count_q + CntW'(enq0) + CntW'(enq1) - CntW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CntW'(DEPTH));
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i].committed <= committed_next[i];
            end
            // Enqueue targets only free slots, so it never collides with a commit;
            // the controller supplies entries with committed already cleared.
            if (enq0) begin
                mem_q[tail_q] <= enq0_entry;
            end
            if (enq1) begin
                mem_q[wr1_idx] <= enq1_entry;
            end
        end
    end

    assign entries = mem_q;
    assign head    = head_q;
    assign count   = count_q;
    assign empty   = empty_q;
    assign full    = full_q;

endmodule

// File: rtl/store_queue_ctrl.sv
// Store queue controller: accepts two store-path results per cycle, marks entries
// committed as the ROB retires them, and drains committed stores to data memory
// one at a time.
//
// Ports:
//   clk, rst_n                           clock, synchronous active-low reset
//   s0_valid/addr/data/tag, s0_ready     older store-path result
//   s1_valid/addr/data/tag, s1_ready     younger store-path result
//   commit_valid, commit_tag             ROB retire of a store by instruction number
//   flush                                drop all uncommitted entries
//   mem_we, mem_addr, mem_wdata          registered memory write request
//   mem_ack                              memory accepted the write
//   count, empty, full                   registered occupancy status
module store_queue_ctrl
    import sq_pkg::*;
#(
    parameter int unsigned DEPTH = SqDepthDefault
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s0_valid,
    input  logic [31:0]            s0_addr,
    input  logic [31:0]            s0_data,
    input  logic [31:0]            s0_tag,
    input  logic                   s1_valid,
    input  logic [31:0]            s1_addr,
    input  logic [31:0]            s1_data,
    input  logic [31:0]            s1_tag,
    output logic                   s0_ready,
    output logic                   s1_ready,
    input  logic                   commit_valid,
    input  logic [31:0]            commit_tag,
    input  logic                   flush,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic                   mem_ack,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    sq_entry_t        entries [DEPTH];
    sq_entry_t        head_entry;
    sq_entry_t        enq0_entry, enq1_entry;
    logic [PtrW-1:0]  head;
    logic [CntW-1:0]  free;
    logic             enq0, enq1, deq;
    logic [DEPTH-1:0] commit_set;
    logic             hit;
    logic [PtrW-1:0]  idx;

    drain_state_e     state_q, state_d;
    logic             mem_we_d;
    logic [31:0]      mem_addr_d, mem_wdata_d;

    // Space comes from the registered count only: a dequeue this cycle frees nothing yet.
    assign free = CntW'(DEPTH) - count;

    always_comb begin
        s0_ready = !flush && (free != '0);
        // s1 may take the last slot only if s0 is not competing for it.
        s1_ready = !flush && ((free >= CntW'(2)) || ((free == CntW'(1)) && !s0_valid));
        enq0     = s0_valid && s0_ready;
        enq1     = s1_valid && s1_ready;
    end

    assign enq0_entry = '{addr: s0_addr, data: s0_data, tag: s0_tag, committed: 1'b0};
    assign enq1_entry = '{addr: s1_addr, data: s1_data, tag: s1_tag, committed: 1'b0};

    // First occupied, uncommitted entry from head with a matching tag gets committed.
    always_comb begin
        commit_set = '0;
        hit        = 1'b0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PtrW'(k);
            if (commit_valid && !hit && (CntW'(k) < count) && !entries[idx].committed &&
                (entries[idx].tag == commit_tag)) begin
                commit_set[idx] = 1'b1;
                hit             = 1'b1;
            end
        end
    end

    assign head_entry = entries[head];

    always_comb begin
        state_d     = state_q;
        deq         = 1'b0;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        unique case (state_q)
            StIdle: begin
                if ((count != '0) && head_entry.committed) begin
                    state_d     = StWrite;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = head_entry.addr;
                    mem_wdata_d = head_entry.data;
                end
            end
            StWrite: begin
                if (mem_ack) begin
                    state_d  = StIdle;
                    deq      = 1'b1;
                    mem_we_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    sq_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .enq0       (enq0),
        .enq0_entry (enq0_entry),
        .enq1       (enq1),
        .enq1_entry (enq1_entry),
        .commit_set (commit_set),
        .deq        (deq),
        .flush      (flush),
        .entries    (entries),
        .head       (head),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

endmodule

// File: tb/tb_store_queue_ctrl.sv
module tb_store_queue_ctrl;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s0_valid, s1_valid;
    logic [31:0] s0_addr, s0_data, s0_tag, s1_addr, s1_data, s1_tag;
    logic        s0_ready, s1_ready;
    logic        commit_valid, flush, mem_ack;
    logic [31:0] commit_tag;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  count;
    logic        empty, full;

    always #5 clk = ~clk;

    store_queue_ctrl #(
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s0_valid     (s0_valid),
        .s0_addr      (s0_addr),
        .s0_data      (s0_data),
        .s0_tag       (s0_tag),
        .s1_valid     (s1_valid),
        .s1_addr      (s1_addr),
        .s1_data      (s1_data),
        .s1_tag       (s1_tag),
        .s0_ready     (s0_ready),
        .s1_ready     (s1_ready),
        .commit_valid (commit_valid),
        .commit_tag   (commit_tag),
        .flush        (flush),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .count        (count),
        .empty        (empty),
        .full         (full)
    );

    typedef struct packed {
        logic        rst_n;
        logic        s0v;
        logic [31:0] s0a, s0d, s0t;
        logic        s1v;
        logic [31:0] s1a, s1d, s1t;
        logic        cv;
        logic [31:0] ct;
        logic        fl;
        logic        ack;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        r0, r1;
        logic [2:0]  cnt;
        logic        we;
        logic [31:0] addr, wdata;
    } vec_t;

    typedef struct {
        logic [31:0] addr, data, tag;
        logic        c;
    } m_entry_t;

    // Reference model: an ordered list of entries plus the write-port state.
    m_entry_t    mq[$];
    logic        m_we;
    logic [31:0] m_addr, m_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic v0, input logic [31:0] a0, d0, t0,
                                 input logic v1, input logic [31:0] a1, d1, t1,
                                 input logic cv, input logic [31:0] ct,
                                 input logic fl, input logic ack);
        stim_t s;
        s.rst_n = 1'b1;
        s.s0v = v0; s.s0a = a0; s.s0d = d0; s.s0t = t0;
        s.s1v = v1; s.s1a = a1; s.s1d = d1; s.s1t = t1;
        s.cv = cv; s.ct = ct; s.fl = fl; s.ack = ack;
        return s;
    endfunction

    function automatic stim_t idle_s(input logic ack);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ack);
    endfunction

    function automatic stim_t rst_s();
        stim_t s;
        s = idle_s(1'b0);
        s.rst_n = 1'b0;
        return s;
    endfunction

    function automatic vec_t vr(input stim_t s, input logic r0, r1, input logic [2:0] cnt,
                                input logic we, input logic [31:0] addr, wdata);
        vec_t v;
        v.s = s; v.r0 = r0; v.r1 = r1; v.cnt = cnt; v.we = we; v.addr = addr; v.wdata = wdata;
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
    endtask

    task automatic model_update(input stim_t s, input logic r0, input logic r1);
        logic     start;
        int       fi;
        m_entry_t e;
        if (!s.rst_n) begin
            model_reset();
            return;
        end
        start = !m_we && (mq.size() > 0) && mq[0].c;
        if (s.cv) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].c && mq[i].tag == s.ct) begin
                    e = mq[i]; e.c = 1'b1; mq[i] = e;
                    break;
                end
            end
        end
        if (s.fl) begin
            fi = mq.size();
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].c) begin
                    fi = i;
                    break;
                end
            end
            while (mq.size() > fi) void'(mq.pop_back());
        end
        if (m_we && s.ack) begin
            void'(mq.pop_front());
            m_we = 1'b0;
        end else if (start) begin
            m_we    = 1'b1;
            m_addr  = mq[0].addr;
            m_wdata = mq[0].data;
        end
        if (s.s0v && r0) begin
            e.addr = s.s0a; e.data = s.s0d; e.tag = s.s0t; e.c = 1'b0;
            mq.push_back(e);
        end
        if (s.s1v && r1) begin
            e.addr = s.s1a; e.data = s.s1d; e.tag = s.s1t; e.c = 1'b0;
            mq.push_back(e);
        end
    endtask

    task automatic apply(input stim_t s);
        rst_n = s.rst_n;
        s0_valid = s.s0v; s0_addr = s.s0a; s0_data = s.s0d; s0_tag = s.s0t;
        s1_valid = s.s1v; s1_addr = s.s1a; s1_data = s.s1d; s1_tag = s.s1t;
        commit_valid = s.cv; commit_tag = s.ct; flush = s.fl; mem_ack = s.ack;
    endtask

    // One clock: drive, check readies against the model, clock, check registered outputs.
    task automatic step(input stim_t s, output logic r0_seen, output logic r1_seen);
        int   free;
        logic r0, r1;
        apply(s);
        #1;
        free = DEPTH - mq.size();
        r0   = !s.fl && (free >= 1);
        r1   = !s.fl && ((free >= 2) || (free == 1 && !s.s0v));
        r0_seen = s0_ready;
        r1_seen = s1_ready;
        check("model_s0_ready", 32'(s0_ready), 32'(r0));
        check("model_s1_ready", 32'(s1_ready), 32'(r1));
        model_update(s, r0, r1);
        @(posedge clk);
        #1;
        check("model_count", 32'(count), 32'(mq.size()));
        check("model_empty", 32'(empty), 32'(mq.size() == 0));
        check("model_full", 32'(full), 32'(mq.size() == DEPTH));
        check("model_mem_we", 32'(mem_we), 32'(m_we));
        if (m_we) begin
            check("model_mem_addr", mem_addr, m_addr);
            check("model_mem_wdata", mem_wdata, m_wdata);
        end
    endtask

    task automatic run(input stim_t s);
        logic a, b;
        step(s, a, b);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl [9];
        logic        r0, r1;
        stim_t       s;
        logic [31:0] a;

        tbl[0] = vr(mk(1, 'h100, 'hAA, 10, 1, 'h104, 'hBB, 11, 0, 0, 0, 0), 1, 1, 2, 0, 0, 0);
        tbl[1] = vr(mk(1, 'h108, 'hCC, 12, 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 3, 0, 0, 0);
        tbl[2] = vr(mk(1, 'h10C, 'hDD, 13, 1, 'h110, 'hEE, 14, 0, 0, 0, 0), 1, 0, 4, 0, 0, 0);
        tbl[3] = vr(mk(1, 'h114, 'hFF, 15, 1, 'h118, 'h11, 16, 1, 10, 0, 0), 0, 0, 4, 0, 0, 0);
        tbl[4] = vr(idle_s(0), 0, 0, 4, 1, 'h100, 'hAA);
        tbl[5] = vr(idle_s(0), 0, 0, 4, 1, 'h100, 'hAA);
        tbl[6] = vr(idle_s(0), 0, 0, 4, 1, 'h100, 'hAA);
        tbl[7] = vr(idle_s(1), 0, 0, 3, 0, 0, 0);
        tbl[8] = vr(idle_s(1), 1, 1, 3, 0, 0, 0);

        apply(rst_s());
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("reset_count", 32'(count), 0);
        check("reset_empty", 32'(empty), 1);
        check("reset_full", 32'(full), 0);
        check("reset_mem_we", 32'(mem_we), 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);

        // Dual enqueue, partial room, full, commit and held drain.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].s, r0, r1);
            check($sformatf("row%0d_s0_ready", i), 32'(r0), 32'(tbl[i].r0));
            check($sformatf("row%0d_s1_ready", i), 32'(r1), 32'(tbl[i].r1));
            check($sformatf("row%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            check($sformatf("row%0d_full", i), 32'(full), 32'(tbl[i].cnt == 3'(DEPTH)));
            check($sformatf("row%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].we));
            if (tbl[i].we) begin
                check($sformatf("row%0d_mem_addr", i), mem_addr, tbl[i].addr);
                check($sformatf("row%0d_mem_wdata", i), mem_wdata, tbl[i].wdata);
            end
        end

        // Commit of an absent tag changes nothing.
        run(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 99, 0, 0));
        run(idle_s(0));
        run(idle_s(0));
        check("nomatch_count", 32'(count), 3);
        check("nomatch_mem_we", 32'(mem_we), 0);

        // A store enqueued on the commit edge is not a commit candidate.
        run(rst_s());
        run(mk(1, 'h500, 'h55, 5, 0, 0, 0, 0, 1, 5, 0, 0));
        run(idle_s(0));
        run(idle_s(0));
        check("sameedge_count", 32'(count), 1);
        check("sameedge_mem_we", 32'(mem_we), 0);

        // Flush with commit in the same cycle keeps only the committed head.
        run(rst_s());
        run(mk(1, 'h300, 'h20, 20, 1, 'h304, 'h21, 21, 0, 0, 0, 0));
        run(mk(1, 'h308, 'h22, 22, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(1, 'h30C, 'h23, 23, 1, 'h310, 'h24, 24, 1, 20, 1, 0), r0, r1);
        check("flush_s0_ready", 32'(r0), 0);
        check("flush_s1_ready", 32'(r1), 0);
        check("flush_count", 32'(count), 1);
        run(idle_s(0));
        check("flush_drain_we", 32'(mem_we), 1);
        check("flush_drain_addr", mem_addr, 'h300);
        check("flush_drain_data", mem_wdata, 'h20);
        run(idle_s(1));
        check("flush_drain_count", 32'(count), 0);
        check("flush_drain_empty", 32'(empty), 1);

        // Reset while a write is outstanding.
        run(rst_s());
        run(mk(1, 'h400, 'h30, 30, 1, 'h404, 'h31, 31, 0, 0, 0, 0));
        run(mk(1, 'h408, 'h32, 32, 0, 0, 0, 0, 1, 30, 0, 0));
        run(idle_s(0));
        check("rstwr_we_before", 32'(mem_we), 1);
        check("rstwr_count_before", 32'(count), 3);
        run(rst_s());
        check("rstwr_mem_we", 32'(mem_we), 0);
        check("rstwr_count", 32'(count), 0);
        check("rstwr_empty", 32'(empty), 1);

        // Six enqueue/drain pairs walk the pointers around the ring.
        for (int p = 0; p < 6; p++) begin
            a = 32'h200 + 32'(p * 4);
            run(mk(1, a, 32'(p * 17 + 1), 32'(40 + p), 0, 0, 0, 0, 0, 0, 0, 0));
            run(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'(40 + p), 0, 0));
            run(idle_s(0));
            check($sformatf("wrap%0d_addr", p), mem_addr, a);
            check($sformatf("wrap%0d_data", p), mem_wdata, 32'(p * 17 + 1));
            run(idle_s(1));
            check($sformatf("wrap%0d_count", p), 32'(count), 0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            s = mk($urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 7),
                   ($urandom_range(0, 1) == 1), $urandom_range(0, 7),
                   ($urandom_range(0, 19) == 0), $urandom_range(0, 1));
            s.rst_n = ($urandom_range(0, 199) != 0);
            run(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_queue_ctrl.md
STORE_QUEUE_CTRL -- requirements
Module: store_queue_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, number of store-queue entries (power of two, 2..16).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 s0_valid/s0_addr/s0_data/s0_tag  in  1/32/32/32  older store-path result: address, store data, instruction number.
REQ-005 s1_valid/s1_addr/s1_data/s1_tag  in  1/32/32/32  younger store-path result, same meaning.
REQ-006 s0_ready, s1_ready  out  1  entry accepted on this edge when valid && ready.
REQ-007 commit_valid/commit_tag  in  1/32  ROB retires store with that instruction number.
REQ-008 flush  in  1  mispredict; discard all uncommitted entries.
REQ-009 mem_we/mem_addr/mem_wdata  out  1/32/32  data-memory write request, registered.
REQ-010 mem_ack  in  1  memory accepted the write this cycle.
REQ-011 count  out  $clog2(DEPTH)+1  occupied entries; empty, full  out  1  status flags.

Function
REQ-012 Circular FIFO, head/tail pointers wrap modulo DEPTH; entry = {addr, data, tag, committed}.
REQ-013 Free count from registered count only; same-cycle dequeue never frees space for same-cycle enqueue.
REQ-014 s0_ready = !flush && free>=1.
REQ-015 s1_ready = !flush && (free>=2 || (free==1 && !s0_valid)); s1 never enqueued ahead of a pending s0.
REQ-016 Both accepted same edge: s0 written at tail, s1 at tail+1, tail advances by 2.
REQ-017 Enqueued entries start with committed=0.
REQ-018 Commit: commit_tag compared against all occupied uncommitted entries; first match from head gets committed=1; no match ignored; at most one commit per cycle.
REQ-019 Entries enqueued on the same edge are not commit candidates.
REQ-020 Drain FSM states IDLE, WRITE.
REQ-021 IDLE -> WRITE when head occupied and committed; next cycle mem_we=1, mem_addr/mem_wdata = head entry.
REQ-022 WRITE holds mem_we and outputs stable until mem_ack; on mem_ack head dequeued, pointer advances, FSM -> IDLE, mem_we=0 next cycle.
REQ-023 Throughput: at most one store per 2 cycles (IDLE cycle between writes).
REQ-024 Flush: tail set to first uncommitted entry from head; committed entries and in-progress WRITE unaffected.
REQ-025 Commit and flush same cycle: commit applied first, then flush.
REQ-026 Flush cycle: no enqueue (both ready=0).
REQ-027 mem_ack while IDLE ignored.
REQ-028 empty = (count==0), full = (count==DEPTH), both registered.

Reset
REQ-029 rst_n=0 at edge: FSM IDLE, head=tail=0, count=0, all committed=0, mem_we=0, mem_addr=0, mem_wdata=0, empty=1, full=0.
REQ-030 Reset during WRITE abandons the write; mem_we=0 from next cycle; entries lost.

Structure
REQ-031 Shared package sq_pkg: FSM state enum, entry struct type, default DEPTH constant.
REQ-032 Entry storage and pointer logic in sub-module sq_fifo_mem; commit match, ready and drain FSM in store_queue_ctrl.

Verification
REQ-033 Dual enqueue: empty, s0(tag 10, addr 0x100, data 0xAA) + s1(tag 11) same cycle -> count=2, s0 at head.
REQ-034 Partial room: count=3 of 4, both valid -> only s0 accepted, s1_ready=0, full=1 next cycle.
REQ-035 Drain: commit tag 10 -> mem_we=1, mem_addr=0x100, mem_wdata=0xAA 2 cycles later; held 3 cycles with mem_ack low; ack -> count decrements, mem_we=0 next cycle.
REQ-036 Flush: tags 20,21,22 queued, 20 committed -> flush leaves count=1, tag 20 still drains.
REQ-037 Commit tag 99 with no match -> no state change; commit tag 5 enqueued same cycle -> not committed.
REQ-038 Reset in WRITE with count=3 -> next cycle mem_we=0, count=0, empty=1; wrap after 6 enqueue/drain pairs with DEPTH=4 correct.
